// File: rtl/inst_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package inst_prefetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ENTRY_W = 2 * INSTR_W;

  // Fetch FSM: idle, waiting on a live request, waiting on a request to be discarded.
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_t;

  // One buffered fetch result: the pc it was fetched from and the instruction word.
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
    return {a[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// DEPTH-entry FIFO of fetch results with synchronous flush; head is read combinationally.
module inst_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_eff;
  logic            pop_eff;

  // A flush wins over any same-cycle push or pop.
  assign push_eff = push & ~flush;
  assign pop_eff  = pop & ~flush;
  assign head     = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + PW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_eff) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // The fetch FSM is responsible for never over- or under-running the buffer.
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push_eff && !pop_eff && count == CW'(DEPTH)));
  underflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(pop_eff && count == '0));

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction fetcher: one outstanding imem request, results buffered for the datapath.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int unsigned          DEPTH    = 4,
  parameter logic [INSTR_W-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    cpu_rst,
  input  logic                    cpu_en,
  input  logic                    redirect_en,
  input  logic [INSTR_W-1:0]      redirect_pc,
  output logic                    imem_ren,
  output logic [INSTR_W-1:0]      imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_W-1:0]      imem_data,
  output logic                    out_valid,
  output logic [INSTR_W-1:0]      out_addr,
  output logic [INSTR_W-1:0]      out_data,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if_state_t          state;
  logic [INSTR_W-1:0] fetch_pc;
  logic [INSTR_W-1:0] target_pc;
  logic               push;
  logic               pop;
  logic               can_issue;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

  // Handshake decode; a redirect suppresses both sides of the buffer this cycle.
  assign target_pc  = word_align(redirect_pc);
  assign push       = (state == IF_WAIT) & imem_ack & ~redirect_en;
  assign pop        = out_valid & out_ready & cpu_en & ~redirect_en;
  assign can_issue  = cpu_en & (count < CW'(DEPTH)) & ~redirect_en;
  assign push_entry = '{pc: imem_addr, instr: imem_data};
  assign out_valid  = (count != '0);
  assign out_addr   = head.pc;
  assign out_data   = head.instr;

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (cpu_rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_en),
    .count      (count),
    .head       (head)
  );

  // Fetch FSM with registered request outputs and fetch pointer.
  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state     <= IF_IDLE;
      fetch_pc  <= RESET_PC;
      imem_ren  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        IF_IDLE: begin
          if (redirect_en) begin
            fetch_pc <= target_pc;
          end else if (can_issue) begin
            imem_ren  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (redirect_en) begin
            fetch_pc <= target_pc;
            if (imem_ack) begin
              imem_ren <= 1'b0;
              state    <= IF_IDLE;
            end else begin
              state    <= IF_DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + INSTR_W'(4);
            imem_ren <= 1'b0;
            state    <= IF_IDLE;
          end
        end
        IF_DROP: begin
          if (redirect_en) fetch_pc <= target_pc;
          if (imem_ack) begin
            imem_ren <= 1'b0;
            state    <= IF_IDLE;
          end
        end
        default: begin
          imem_ren <= 1'b0;
          state    <= IF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed and randomized bench for inst_prefetch with a transaction-level reference model.
module tb_inst_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        cpu_en = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  always #5 clk = ~clk;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .cpu_rst     (cpu_rst),
    .cpu_en      (cpu_en),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_ren    (imem_ren),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .out_valid   (out_valid),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Memory model knobs.
  int lat      = 2;
  int wait_cnt = 0;
  bit force_ack = 1'b0;

  // Reference model: expected buffer contents, next fetch address, outstanding request.
  logic [63:0] q[$];
  logic [31:0] m_fetch = RESET_PC;
  bit          m_out = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_out_addr = '0;
  logic [31:0] issued[$];
  logic [31:0] popped[$];
  int          pop_cyc[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fetch    = RESET_PC;
    m_out      = 1'b0;
    m_drop     = 1'b0;
    m_out_addr = '0;
  endtask

  // One clock: memory responds, edge, model advances, outputs compared.
  task automatic cycle();
    logic        p_en, p_rdy, p_redir, p_ack, p_rst;
    logic [31:0] p_rpc;
    logic [63:0] tmp;
    int          pre;
    imem_ack = 1'b0;
    if (imem_ren === 1'b1 && !cpu_rst) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        imem_ack  = 1'b1;
        imem_data = mem_fn(imem_addr);
        wait_cnt  = 0;
      end
    end else begin
      wait_cnt = 0;
      if (force_ack) begin
        imem_ack  = 1'b1;
        imem_data = 32'hdead_beef;
      end
    end
    force_ack = 1'b0;
    p_en = cpu_en; p_rdy = out_ready; p_redir = redirect_en;
    p_ack = imem_ack; p_rst = cpu_rst; p_rpc = redirect_pc;
    @(posedge clk);
    #1;
    cyc++;
    if (p_rst) begin
      model_reset();
    end else begin
      pre = q.size();
      if (pre != 0 && p_rdy && p_en && !p_redir) begin
        tmp = q.pop_front();
        popped.push_back(tmp[63:32]);
        pop_cyc.push_back(cyc);
      end
      if (p_redir) begin
        q.delete();
        m_fetch = {p_rpc[31:2], 2'b00};
        if (m_out) begin
          if (p_ack) m_out = 1'b0;
          else       m_drop = 1'b1;
        end
      end else if (m_out && p_ack) begin
        if (!m_drop) begin
          q.push_back({m_out_addr, mem_fn(m_out_addr)});
          m_fetch = m_fetch + 32'd4;
        end
        m_out = 1'b0;
      end else if (!m_out && p_en && pre < DEPTH) begin
        m_out      = 1'b1;
        m_drop     = 1'b0;
        m_out_addr = m_fetch;
        issued.push_back(m_fetch);
      end
    end
    chk("imem_ren", 32'(imem_ren), 32'(m_out));
    if (m_out) chk("imem_addr", imem_addr, m_out_addr);
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_addr", out_addr, q[0][63:32]);
      chk("out_data", out_data, q[0][31:0]);
    end
  endtask

  task automatic wait_ren(input logic lvl, input string tag);
    for (int i = 0; i < 12 && imem_ren !== lvl; i++) cycle();
    chk(tag, 32'(imem_ren), 32'(lvl));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && out_valid !== 1'b1; i++) cycle();
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    redirect_en = 1'b0;
    cycle();
    cycle();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ren", 32'(imem_ren), 32'd0);
    cpu_rst = 1'b0;
    issued.delete();
    popped.delete();
    pop_cyc.delete();
  endtask

  initial begin
    int c0;

    // Reset and streaming with 2-cycle memory.
    do_reset();
    lat = 2; out_ready = 1'b1; cpu_en = 1'b1;
    repeat (14) cycle();
    chk("t1_npop", 32'(popped.size() >= 3), 32'd1);
    chk("t1_iss0", issued[0], 32'h0);
    chk("t1_iss1", issued[1], 32'h4);
    chk("t1_iss2", issued[2], 32'h8);
    chk("t1_pop0", popped[0], 32'h0);
    chk("t1_pop1", popped[1], 32'h4);
    chk("t1_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
    chk("t1_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd3);

    // Fill the buffer with the consumer stalled.
    do_reset();
    lat = 1; out_ready = 1'b0;
    repeat (16) cycle();
    chk("t2_full", 32'(count), 32'd4);
    chk("t2_noreq", 32'(imem_ren), 32'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t2_pop0", popped[0], 32'h0);
    wait_ren(1'b1, "t2_refetch_to");
    chk("t2_addr10", imem_addr, 32'h10);

    // Redirect while a slow request is outstanding.
    do_reset();
    lat = 1; out_ready = 1'b0;
    repeat (4) cycle();
    wait_ren(1'b1, "t3_ren_to");
    lat = 4;
    cycle();
    redirect_en = 1'b1; redirect_pc = 32'h103;
    cycle();
    redirect_en = 1'b0;
    chk("t3_flush", 32'(count), 32'd0);
    chk("t3_held", 32'(imem_ren), 32'd1);
    wait_ren(1'b0, "t3_drop_to");
    chk("t3_nopush", 32'(count), 32'd0);
    lat = 2;
    wait_ren(1'b1, "t3_reiss_to");
    chk("t3_addr", imem_addr, 32'h100);
    out_ready = 1'b1;
    wait_valid("t3_valid_to");
    chk("t3_out_addr", out_addr, 32'h100);
    chk("t3_out_data", out_data, mem_fn(32'h100));

    // Redirect coinciding with the ack.
    do_reset();
    lat = 1; out_ready = 1'b0;
    for (int i = 0; i < 20 && !(imem_ren === 1'b1 && count == 3'd2); i++) cycle();
    chk("t4_setup", 32'(count), 32'd2);
    redirect_en = 1'b1; redirect_pc = 32'h2000;
    cycle();
    redirect_en = 1'b0;
    chk("t4_flush", 32'(count), 32'd0);
    chk("t4_ren_off", 32'(imem_ren), 32'd0);
    wait_ren(1'b1, "t4_reiss_to");
    chk("t4_addr", imem_addr, 32'h2000);
    out_ready = 1'b1;
    wait_valid("t4_valid_to");
    chk("t4_out_addr", out_addr, 32'h2000);

    // CPU disabled mid-request.
    do_reset();
    lat = 3; out_ready = 1'b1;
    wait_ren(1'b1, "t5_ren_to");
    cpu_en = 1'b0;
    c0 = int'(count);
    wait_ren(1'b0, "t5_ack_to");
    chk("t5_pushed", 32'(count), 32'(c0 + 1));
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t5_noissue", 32'(imem_ren), 32'd0);
    end
    chk("t5_nopop", 32'(count), 32'(c0 + 1));
    cpu_en = 1'b1;
    wait_ren(1'b1, "t5_resume_to");

    // Asynchronous reset between edges while waiting.
    do_reset();
    lat = 1; out_ready = 1'b0;
    repeat (4) cycle();
    wait_ren(1'b1, "t6_ren_to");
    lat = 4;
    cycle();
    #2;
    cpu_rst = 1'b1;
    #1;
    chk("t6_ren_async", 32'(imem_ren), 32'd0);
    chk("t6_count_async", 32'(count), 32'd0);
    chk("t6_valid_async", 32'(out_valid), 32'd0);
    model_reset();
    wait_cnt = 0;
    cycle();
    cpu_rst = 1'b0;
    force_ack = 1'b1;
    cycle();
    chk("t6_first_ren", 32'(imem_ren), 32'd1);
    chk("t6_first_addr", imem_addr, RESET_PC);
    lat = 2;
    repeat (6) cycle();

    // Randomized traffic against the reference model.
    out_ready = 1'b1;
    repeat (800) begin
      cpu_en      = ($urandom_range(0, 9) != 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      redirect_en = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hffff_fff0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      if (imem_ren !== 1'b1) begin
        lat       = $urandom_range(1, 4);
        force_ack = ($urandom_range(0, 9) == 0);
      end
      cycle();
    end
    redirect_en = 1'b0;
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
